// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit: IF stage with PC, req/ack instruction fetch, 1-entry skid buffer and IF/ID register.
// Optional counters stall_cycles / kill_count are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush_IFID,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_ID,
  output logic [31:0] pc_ID,
  output logic        valid_ID
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] kill_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2,
    BUF  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] redirect_pc;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic [31:0] target;
  logic        src_valid;
  logic [31:0] src_instr;
  logic [31:0] src_pc;
  logic        unused_target_lsbs;

  assign target             = {branch_target[31:2], 2'b00};
  assign unused_target_lsbs = ^branch_target[1:0];
  // pc only moves on ack or while no request is pending, so the address stays stable.
  assign imem_addr          = pc;

  // Instruction offered to IF/ID this cycle; a redirect invalidates both sources.
  always_comb begin
    src_valid = 1'b0;
    src_instr = skid_instr;
    src_pc    = skid_pc;
    if (!branch_taken) begin
      if (state == REQ && imem_ack) begin
        src_valid = 1'b1;
        src_instr = imem_rdata;
        src_pc    = pc;
      end else if (state == BUF) begin
        src_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      imem_req    <= 1'b0;
      pc          <= RESET_PC;
      redirect_pc <= RESET_PC;
      skid_instr  <= NOP_INSTR;
      skid_pc     <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
          if (branch_taken) pc <= target;
        end
        REQ: begin
          if (branch_taken) begin
            if (imem_ack) begin
              pc <= target;
            end else begin
              redirect_pc <= target;
              state       <= KILL;
            end
          end else if (imem_ack) begin
            pc <= pc + 32'd4;
            if (stall) begin
              skid_instr <= imem_rdata;
              skid_pc    <= pc;
              state      <= BUF;
              imem_req   <= 1'b0;
            end
          end
        end
        KILL: begin
          if (branch_taken) redirect_pc <= target;
          if (imem_ack) begin
            pc    <= branch_taken ? target : redirect_pc;
            state <= REQ;
          end
        end
        BUF: begin
          if (branch_taken) begin
            pc       <= target;
            state    <= REQ;
            imem_req <= 1'b1;
          end else if (!stall) begin
            state    <= REQ;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_ID <= NOP_INSTR;
      pc_ID    <= 32'h0;
      valid_ID <= 1'b0;
    end else if (flush_IFID) begin
      instr_ID <= NOP_INSTR;
      valid_ID <= 1'b0;
    end else if (!stall) begin
      if (src_valid) begin
        instr_ID <= src_instr;
        pc_ID    <= src_pc;
        valid_ID <= 1'b1;
      end else begin
        instr_ID <= NOP_INSTR;
        valid_ID <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic drop;
  assign drop = (state == REQ  && imem_ack && branch_taken) ||
                (state == BUF  && branch_taken) ||
                (state == KILL && imem_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= 32'h0;
      kill_count   <= 32'h0;
    end else begin
      if (stall) stall_cycles <= stall_cycles + 32'd1;
      if (drop)  kill_count   <= kill_count + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// tb_fetch_unit: directed scenarios plus randomized traffic checked against a queue-based fetch model.
module tb_fetch_unit;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;
  localparam logic [31:0] XOR_PAT  = 32'hA5A5_0000;
  localparam logic [97:0] RST_VEC  = {1'b0, 32'h0, NOP, 32'h0, 1'b0};
  localparam logic [97:0] RST_VEC2 = {1'b0, WRAP_PC, NOP, 32'h0, 1'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush_IFID = 1'b0, branch_taken = 1'b0, imem_ack = 1'b0;
  logic [31:0] branch_target = 32'h0, imem_rdata = 32'h0, rdata2 = 32'h0;
  logic        imem_req, valid_ID, req2, valid2;
  logic [31:0] imem_addr, instr_ID, pc_ID, addr2, instr2, pcid2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles, kill_count, sc2, kc2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush_IFID(flush_IFID),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_ID(instr_ID), .pc_ID(pc_ID), .valid_ID(valid_ID)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .kill_count(kill_count)
`endif
  );

  fetch_unit #(.RESET_PC(WRAP_PC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush_IFID(flush_IFID),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(req2), .imem_addr(addr2), .imem_ack(imem_ack), .imem_rdata(rdata2),
    .instr_ID(instr2), .pc_ID(pcid2), .valid_ID(valid2)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cycles(sc2), .kill_count(kc2)
`endif
  );

  logic [97:0] dut_vec, wrap_vec;
  assign dut_vec  = {imem_req, imem_addr, instr_ID, pc_ID, valid_ID};
  assign wrap_vec = {req2, addr2, instr2, pcid2, valid2};

  // Reference model: a fetch is either live, doomed by a redirect, or parked in a 1-deep queue.
  bit          m_started, m_doomed;
  logic [31:0] m_pc, m_redirect, m_instr, m_pcid;
  logic        m_valid;
  logic [63:0] m_held[$];
  int unsigned m_kills, m_stalls;

  function automatic logic m_req();
    return m_started && (m_held.size() == 0);
  endfunction

  function automatic logic [97:0] exp_vec();
    return {m_req(), m_pc, m_instr, m_pcid, m_valid};
  endfunction

  task automatic mdl_reset();
    m_started = 0; m_doomed = 0; m_pc = 32'h0; m_redirect = 32'h0;
    m_instr = NOP; m_pcid = 32'h0; m_valid = 1'b0; m_held.delete();
    m_kills = 0; m_stalls = 0;
  endtask

  task automatic mdl_step(input logic s, input logic f, input logic b, input logic [31:0] t,
                          input logic a, input logic [31:0] rd);
    logic [31:0] tg;
    logic [63:0] item;
    bit          got;
    tg = t & 32'hFFFF_FFFC;
    got = 0;
    item = 64'h0;
    if (s) m_stalls++;
    if (!m_started) begin
      m_started = 1;
      if (b) m_pc = tg;
    end else if (m_held.size() != 0) begin
      if (b) begin m_held.delete(); m_pc = tg; m_kills++; end
      else if (!s) begin item = m_held.pop_front(); got = 1; end
    end else if (m_doomed) begin
      if (b) m_redirect = tg;
      if (a) begin m_pc = m_redirect; m_doomed = 0; m_kills++; end
    end else if (b) begin
      if (a) begin m_pc = tg; m_kills++; end
      else begin m_doomed = 1; m_redirect = tg; end
    end else if (a) begin
      if (s) m_held.push_back({rd, m_pc});
      else begin item = {rd, m_pc}; got = 1; end
      m_pc = m_pc + 32'd4;
    end
    if (f) begin
      m_valid = 1'b0; m_instr = NOP;
    end else if (!s) begin
      if (got) begin m_instr = item[63:32]; m_pcid = item[31:0]; m_valid = 1'b1; end
      else begin m_instr = NOP; m_valid = 1'b0; end
    end
  endtask

  // Drive one cycle of inputs at the falling edge, advance the model, return at the next falling edge.
  task automatic apply(input logic s, input logic f, input logic b, input logic [31:0] t,
                       input logic a, input logic [31:0] rd);
    stall = s; flush_IFID = f; branch_taken = b; branch_target = t; imem_ack = a; imem_rdata = rd;
    mdl_step(s, f, b, t, a, rd);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    stall = 0; flush_IFID = 0; branch_taken = 0; branch_target = 0; imem_ack = 0; imem_rdata = 0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mdl_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== RST_VEC) begin
        errors++; $display("FAIL reset {req,addr,instr,pc,valid}: got %h want %h", dut_vec, RST_VEC);
      end
      checks++;
      if (wrap_vec !== RST_VEC2) begin
        errors++; $display("FAIL reset_wrap: got %h want %h", wrap_vec, RST_VEC2);
      end
    end
  endtask

  task automatic test_streaming();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(0, 0, 0, 32'h0, 1, m_pc ^ XOR_PAT);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL stream model cyc %0d: got %h want %h", i, dut_vec, exp_vec());
      end
      checks++;
      if (imem_addr !== 32'(4 * i) || imem_req !== 1'b1) begin
        errors++; $display("FAIL stream addr cyc %0d: got %h/%b want %h/1", i, imem_addr, imem_req, 32'(4 * i));
      end
      if (i >= 1) begin
        checks++;
        if (pc_ID !== 32'(4 * (i - 1)) || instr_ID !== (32'(4 * (i - 1)) ^ XOR_PAT) || valid_ID !== 1'b1) begin
          errors++; $display("FAIL stream ifid cyc %0d: got pc=%h instr=%h v=%b want pc=%h", i, pc_ID, instr_ID, valid_ID, 32'(4 * (i - 1)));
        end
      end
    end
  endtask

  task automatic test_wait_branch();
    do_reset();
    apply(0, 0, 0, 32'h0, 0, 32'h0);
    apply(0, 0, 1, 32'h100, 0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (imem_addr !== 32'h0 || imem_req !== 1'b1 || valid_ID !== 1'b0) begin
        errors++; $display("FAIL kill_hold %0d: got addr=%h req=%b v=%b want 0/1/0", i, imem_addr, imem_req, valid_ID);
      end
      if (i == 0) apply(0, 0, 0, 32'h0, 0, 32'h0);
    end
    apply(0, 0, 0, 32'h0, 1, 32'hDEAD_0000);
    checks++;
    if (imem_addr !== 32'h100 || valid_ID !== 1'b0 || instr_ID !== NOP) begin
      errors++; $display("FAIL kill_drop: got addr=%h v=%b instr=%h want 100/0/%h", imem_addr, valid_ID, instr_ID, NOP);
    end
    apply(0, 0, 0, 32'h0, 1, 32'h1234_5678);
    checks++;
    if (instr_ID !== 32'h1234_5678 || pc_ID !== 32'h100 || valid_ID !== 1'b1) begin
      errors++; $display("FAIL kill_target: got instr=%h pc=%h v=%b want 12345678/100/1", instr_ID, pc_ID, valid_ID);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL kill model: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_stall_buffer();
    do_reset();
    for (int i = 0; i < 3; i++) apply(0, 0, 0, 32'h0, 1, m_pc ^ XOR_PAT);
    for (int i = 0; i < 4; i++) begin
      apply(1, 0, 0, 32'h0, i == 0, m_pc ^ XOR_PAT);
      checks++;
      if (imem_req !== 1'b0 || pc_ID !== 32'h4 || instr_ID !== (32'h4 ^ XOR_PAT) || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL stall_hold %0d: got %h want req=0 pc=4 model %h", i, dut_vec, exp_vec());
      end
    end
    apply(0, 0, 0, 32'h0, 0, 32'h0);
    checks++;
    if (instr_ID !== (32'h8 ^ XOR_PAT) || pc_ID !== 32'h8 || valid_ID !== 1'b1 ||
        imem_req !== 1'b1 || imem_addr !== 32'hC) begin
      errors++; $display("FAIL stall_release: got %h want instr=%h pc=8 v=1 req=1 addr=c", dut_vec, 32'h8 ^ XOR_PAT);
    end
  endtask

  task automatic test_simultaneous();
    apply(1, 0, 0, 32'h0, 1, 32'hC ^ XOR_PAT);
    checks++;
    if (imem_req !== 1'b0 || pc_ID !== 32'h8) begin
      errors++; $display("FAIL simul_buf: got req=%b pc=%h want 0/8", imem_req, pc_ID);
    end
    apply(1, 1, 1, 32'h41, 0, 32'h0);
    checks++;
    if (valid_ID !== 1'b0 || instr_ID !== NOP || imem_addr !== 32'h40 || imem_req !== 1'b1) begin
      errors++; $display("FAIL simul_all: got v=%b instr=%h addr=%h req=%b want 0/13/40/1", valid_ID, instr_ID, imem_addr, imem_req);
    end
    apply(0, 0, 0, 32'h0, 1, 32'hCAFE_0040);
    checks++;
    if (dut_vec !== exp_vec() || pc_ID !== 32'h40 || instr_ID !== 32'hCAFE_0040) begin
      errors++; $display("FAIL simul_after: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_wrap_reset();
    logic [31:0] p;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rdata2 = ~(WRAP_PC + 32'(4 * (i - 1)));
      apply(0, 0, 0, 32'h0, 1, m_pc ^ XOR_PAT);
      checks++;
      if (addr2 !== WRAP_PC + 32'(4 * i) || req2 !== 1'b1) begin
        errors++; $display("FAIL wrap_addr %0d: got %h want %h", i, addr2, WRAP_PC + 32'(4 * i));
      end
      if (i >= 1) begin
        p = WRAP_PC + 32'(4 * (i - 1));
        checks++;
        if (pcid2 !== p || instr2 !== ~p || valid2 !== 1'b1) begin
          errors++; $display("FAIL wrap_ifid %0d: got pc=%h instr=%h v=%b want pc=%h", i, pcid2, instr2, valid2, p);
        end
      end
    end
    apply(0, 0, 0, 32'h0, 0, 32'h0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (wrap_vec !== RST_VEC2) begin
      errors++; $display("FAIL midreq_reset_wrap: got %h want %h", wrap_vec, RST_VEC2);
    end
    checks++;
    if (dut_vec !== RST_VEC) begin
      errors++; $display("FAIL midreq_reset: got %h want %h", dut_vec, RST_VEC);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic s, f, b, a;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 7) == 0);
      b = ($urandom_range(0, 7) == 0);
      a = ($urandom_range(0, 2) != 0);
      apply(s, f, b, $urandom, a, $urandom);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        if (bad < 10) $display("FAIL random cyc %0d: got %h want %h", i, dut_vec, exp_vec());
        bad++;
      end
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (stall_cycles !== 32'(m_stalls) || kill_count !== 32'(m_kills)) begin
      errors++; $display("FAIL random_perf: got %0d/%0d want %0d/%0d", stall_cycles, kill_count, m_stalls, m_kills);
    end
`endif
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    apply(0, 0, 0, 32'h0, 0, 32'h0);
    apply(0, 0, 1, 32'h80, 1, 32'h1);
    apply(0, 0, 1, 32'hC0, 0, 32'h0);
    apply(0, 0, 0, 32'h0, 1, 32'h2);
    for (int i = 0; i < 5; i++) apply(1, 0, 0, 32'h0, 0, 32'h0);
    checks++;
    if (stall_cycles !== 32'd5 || kill_count !== 32'd2) begin
      errors++; $display("FAIL perf: got stall=%0d kill=%0d want 5/2", stall_cycles, kill_count);
    end
    checks++;
    if (imem_addr !== 32'hC0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL perf_state: got %h want %h", dut_vec, exp_vec());
    end
  endtask
`endif

  initial begin
    mdl_reset();
    test_reset();
    test_streaming();
    test_wait_branch();
    test_stall_buffer();
    test_simultaneous();
    test_wrap_reset();
    test_random();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that receives the `stall`, `flush_IFID` and `branch_taken` control outputs of the hazard detection unit. It owns the program counter, drives a variable-latency instruction-memory request/acknowledge interface, and drives the IF/ID pipeline register into the ID stage. It buffers one returned instruction while ID is stalled, and discards in-flight fetches made obsolete by a taken branch.

## Interface

Parameters:

- `RESET_PC`, default 32'h0000_0000, first fetch address after reset.
- `NOP_INSTR`, default 32'h0000_0013, value loaded into `instr_ID` when IF/ID is flushed (addi x0,x0,0).

Ports (one clock; reset is asynchronous and active-low):

- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `stall` input 1: hold PC and IF/ID.
- `flush_IFID` input 1: squash the IF/ID contents.
- `branch_taken` input 1: redirect fetch to `branch_target`.
- `branch_target` input 32: redirect address; bits [1:0] are ignored and treated as 0.
- `imem_req` output 1: fetch request.
- `imem_addr` output 32: fetch address, word aligned.
- `imem_ack` input 1: transfer complete; `imem_rdata` is valid in the same cycle.
- `imem_rdata` input 32: fetched instruction.
- `instr_ID` output 32: IF/ID instruction.
- `pc_ID` output 32: IF/ID PC.
- `valid_ID` output 1: IF/ID holds a real instruction.

## Operation

State machine states:

- **IDLE**: reset state, `imem_req`=0. Always goes to REQ on the next cycle.
- **REQ**: `imem_req`=1, `imem_addr`=`pc`. Transfer completes on a cycle where `imem_ack`=1.
- **KILL**: `imem_req`=1 and the old address is held stable. The outstanding fetch was made obsolete by a redirect, so its data is dropped on ack. The saved target is in `redirect_pc`. On ack: `pc`<=`redirect_pc`, go to REQ.
- **BUF**: `imem_req`=0. One fetched instruction and its PC are held in the skid buffer while ID is stalled.

Transitions, evaluated with priority branch_taken > stall > normal:

- **REQ + branch_taken**:
  - If `imem_ack`=0: save target, go to KILL.
  - If `imem_ack`=1: drop the data, `pc`<=target, stay in REQ.
- **REQ + ack + stall**: buffer `imem_rdata` and `pc`, `pc`<=`pc`+4, go to BUF.
- **REQ + ack, no stall**: IF/ID loads (`imem_rdata`, `pc`, valid=1), `pc`<=`pc`+4, stay in REQ.
- **BUF + branch_taken**: drop the buffer, `pc`<=target, go to REQ.
- **BUF, no stall**: IF/ID loads the buffer contents, go to REQ.
- **KILL + branch_taken**: overwrite `redirect_pc` with the newest target.

IF/ID register update, in priority order:

1. `flush_IFID`: `valid_ID`=0, `instr_ID`=`NOP_INSTR`, `pc_ID` unchanged.
2. `stall`: hold all IF/ID outputs.
3. Data source available: load it.
4. Otherwise: `valid_ID`<=0 (bubble), `instr_ID`<=`NOP_INSTR`.

General rules:

- PC arithmetic is 32-bit unsigned and wraps: 32'hFFFF_FFFC + 4 = 0.
- `imem_addr` and `imem_req` must not change while a request is unacknowledged, including across stall and branch_taken.
- `stall` and `branch_taken` in the same cycle: the redirect wins and the stall is ignored for fetch state. `flush_IFID` still controls IF/ID.
- `flush_IFID` without `branch_taken`: squashes IF/ID only. PC and fetch state are unaffected.

## Timing

- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `instr_ID`=`NOP_INSTR`, `pc_ID`=0, `valid_ID`=0, state IDLE, `pc`=`RESET_PC`.
- First `imem_req` is asserted in the 1st cycle after `rst_n` deasserts.
- Ack may arrive in the same cycle the request is first asserted (zero wait).
- Latency: the instruction appears on `instr_ID` the cycle after its ack, or the cycle after the stall ends if it was buffered.
- Throughput with `imem_ack` tied high: one instruction per cycle.
- A redirect during REQ without ack: the first target instruction is on `instr_ID` 1 cycle after the ack of the target fetch. The killed fetch never reaches ID.
- Reset asserted mid-request: immediate return to reset values. The memory side is reset by the same `rst_n`.
- Buffer depth is exactly 1. No new request is issued while in BUF.

## Configuration

- **`FETCH_PERF_CNT_EN` defined**: adds outputs `stall_cycles` [31:0] and `kill_count` [31:0], both reset to 0 and wrapping on overflow.
  - `stall_cycles` increments on every cycle with `stall`=1 and `rst_n`=1.
  - `kill_count` increments each time a fetch is dropped because of `branch_taken`: a REQ ack redirect, a BUF drop, or a KILL ack.
- **Undefined**: the ports and counters are absent. Fetch behaviour is identical.

## Test plan

- **Reset and streaming**: `imem_ack` tied 1, `imem_rdata`=`imem_addr`^32'hA5A5_0000 -> `imem_addr` 0,4,8…; `instr_ID`/`pc_ID` follow one cycle behind; `valid_ID`=1 from cycle 2.
- **Wait states**: ack after 3 cycles, with `branch_taken` (target 32'h100) pulsed in wait cycle 1 -> `imem_addr` stays 0 until ack; the data is dropped; the next request is 32'h100; `valid_ID`=0 until the 32'h100 instruction arrives.
- **Stall during ack**: ack at pc 8 with `stall`=1 for 4 cycles -> `imem_req`=0 during the stall; `instr_ID` holds the pc 4 instruction; the pc 8 instruction appears the cycle after the stall drops; the next request is 12.
- **Simultaneous events**: `stall`, `flush_IFID` and `branch_taken` (target 32'h40) all 1 in BUF -> buffer dropped, `valid_ID`=0, `instr_ID`=32'h0000_0013, next `imem_addr`=32'h40.
- **Wrap and mid-request reset**: `RESET_PC`=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0. Then assert `rst_n`=0 during a wait state -> all outputs return to reset values immediately.
- **With `FETCH_PERF_CNT_EN`**: 5 stall cycles and 2 killed fetches -> `stall_cycles`=5, `kill_count`=2.
